// File: rtl/instr_exec_ctrl.sv
// Multi-cycle decode/execute sequencer for 28-bit encoded instructions.
// Fetch handshake in, register-file and req/ack data-memory ports out, owns the PC.
module instr_exec_ctrl #(
    parameter int DATA_W   = 28,
    parameter int ADDR_W   = 8,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [27:0]       instr,
    output logic [4:0]        rf_raddr_a,
    output logic [4:0]        rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              illegal
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_STORE = 5'd2;
    localparam logic [4:0] OP_LOAD  = 5'd3;
    localparam logic [4:0] OP_LOADI = 5'd4;
    localparam logic [4:0] OP_BEQ   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_RETIRE
    } state_t;

    state_t            state_reg, state_next;
    logic [27:0]       instr_reg;
    logic [DATA_W-1:0] a_reg, b_reg, result_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [PC_W-1:0]   pc_reg, target_pc_reg;

    logic [4:0]        opcode, rs, rt, rd;
    logic [7:0]        imm;
    logic              is_store, is_illegal;
    logic [DATA_W-1:0] abs_a, abs_b;

    assign opcode     = instr_reg[27:23];
    assign rs         = instr_reg[22:18];
    assign rt         = instr_reg[17:13];
    assign rd         = instr_reg[12:8];
    assign imm        = instr_reg[7:0];
    assign is_store   = (opcode == OP_STORE);
    assign is_illegal = (opcode > OP_SLT);

    // Negating the most-negative value wraps back to itself, which is the wanted |x|.
    assign abs_a = a_reg[DATA_W-1] ? -a_reg : a_reg;
    assign abs_b = b_reg[DATA_W-1] ? -b_reg : b_reg;

    // Stores read the data-address base from Rd so port A can carry the store data.
    assign rf_raddr_a = rs;
    assign rf_raddr_b = is_store ? rd : rt;
    assign rf_waddr   = rd;
    assign rf_wdata   = result_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = a_reg;
    assign pc         = pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            instr_reg     <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            addr_reg      <= '0;
            pc_reg        <= PC_W'(RESET_PC);
            target_pc_reg <= PC_W'(RESET_PC);
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (instr_valid) instr_reg <= instr;
                end
                S_DECODE: begin
                    a_reg <= rf_rdata_a;
                    b_reg <= rf_rdata_b;
                end
                S_EXEC: begin
                    target_pc_reg <= pc_reg + PC_W'(1);
                    case (opcode)
                        OP_ADD:   result_reg <= a_reg + b_reg;
                        OP_ADDU:  result_reg <= abs_a + abs_b;
                        OP_LOADI: result_reg <= DATA_W'(imm);
                        OP_SLT:   result_reg <= DATA_W'($signed(a_reg) < $signed(b_reg));
                        OP_LOAD:  addr_reg   <= a_reg[ADDR_W-1:0] + ADDR_W'(imm);
                        OP_STORE: addr_reg   <= b_reg[ADDR_W-1:0] + ADDR_W'(imm);
                        OP_BEQ: begin
                            if (a_reg == b_reg)
                                target_pc_reg <= pc_reg + PC_W'($signed(imm));
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack && !is_store) result_reg <= mem_rdata;
                end
                S_RETIRE: pc_reg <= target_pc_reg;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state_reg;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        retire      = 1'b0;
        illegal     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_next = S_DECODE;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE:                state_next = S_MEM;
                    OP_ADD, OP_ADDU, OP_SLT, OP_LOADI: state_next = S_WB;
                    default:                          state_next = S_RETIRE;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ack) state_next = is_store ? S_RETIRE : S_WB;
            end
            S_WB: begin
                rf_we      = 1'b1;
                state_next = S_RETIRE;
            end
            S_RETIRE: begin
                retire     = 1'b1;
                illegal    = is_illegal;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
